usb_fs_nb_tx_pkt: RTL
=====================

# usb_fs_nb_tx_pkt

Byte-level USB full-speed transmit packet framer sitting directly downstream of the IN/OUT protocol engines and upstream of the bit-level NRZI/bit-stuff serializer. On a start strobe it emits the PID byte. For DATA PIDs it then streams payload bytes pulled from the engine and appends the inverted CRC16. It signals packet end once the serializer reports EOP complete.

## Interface
Parameters:
- MaxPktSizeByte, 64, payload byte limit; used only under the length guard.

Ports:
- clk_48mhz_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- link_reset_i  in  1  synchronous abort to idle.
- tx_pkt_start_i  in  1  strobe, start new packet.
- tx_pid_i  in  4  PID to send; sampled with start.
- tx_data_avail_i  in  1  engine has a payload byte on tx_data_i.
- tx_data_get_o  out  1  payload byte consumed this cycle.
- tx_data_i  in  8  current payload byte.
- tx_pkt_end_o  out  1  one-cycle pulse, packet fully on the wire.
- byte_o  out  8  byte to serializer.
- byte_valid_o  out  1  byte_o valid.
- byte_ready_i  in  1  serializer accepts byte_o.
- byte_last_o  out  1  byte_o is last byte of packet.
- eop_done_i  in  1  serializer finished EOP after the last byte.
- busy_o  out  1  framer not idle.

## Operation
- States:
  - StIdle: waiting for a start strobe.
  - StPid: PID byte presented.
  - StData: payload bytes streamed.
  - StCrcLo / StCrcHi: CRC bytes presented.
  - StWaitEop: waiting for the serializer to finish EOP.
- Transfer occurs on byte_valid_o && byte_ready_i.
- StIdle:
  - tx_pkt_start_i latches tx_pid_i and sets crc_q = 16'hFFFF; next state is StPid.
  - Start is ignored in any other state.
- StPid:
  - byte_o = {~pid_q, pid_q}; byte_valid_o = 1.
  - byte_last_o = 1 if pid_q[1:0] != 2'b11 (handshake/other).
  - On transfer: go to StData if DATA type, else StWaitEop.
- StData:
  - byte_o = tx_data_i; byte_valid_o = tx_data_avail_i.
  - tx_data_get_o = tx_data_avail_i && byte_ready_i.
  - On get, crc_q updates with tx_data_i.
  - If tx_data_avail_i = 0, go to StCrcLo the same cycle (no byte sent).
- StCrcLo: byte_o = ~crc_q[7:0]. On transfer, go to StCrcHi.
- StCrcHi: byte_o = ~crc_q[15:8]; byte_last_o = 1. On transfer, go to StWaitEop.
- StWaitEop: eop_done_i pulses tx_pkt_end_o and returns to StIdle.
- CRC16: reflected polynomial 16'hA001 (0x8005), init 16'hFFFF, LSB-first per byte. Transmitted value is the complement, low byte first.
- Zero-length DATA packet: PID followed by CRC bytes 0x00, 0x00.
- link_reset_i (or rst_ni) in any state:
  - Forces StIdle and drops byte_valid_o next cycle.
  - No tx_pkt_end_o; no further tx_data_get_o.
- busy_o = (state != StIdle).

## Timing
- All outputs are 0 in reset and in StIdle.
- byte_valid_o rises the cycle after tx_pkt_start_i.
- tx_data_get_o is combinational from tx_data_avail_i and byte_ready_i. The engine advances its data in the following cycle.
- Each byte is held stable while byte_valid_o && !byte_ready_i.
- tx_pkt_end_o is registered: it asserts the cycle after eop_done_i.
- No back-to-back overlap: the earliest next start is accepted the cycle tx_pkt_end_o is high.

## Configuration
- USB_FS_TX_LEN_LIMIT_EN defined:
  - A byte counter of width $clog2(MaxPktSizeByte+1) counts payload gets.
  - After MaxPktSizeByte gets, the framer leaves StData for StCrcLo regardless of tx_data_avail_i, and tx_data_get_o stays 0.
- USB_FS_TX_LEN_LIMIT_EN undefined: no counter; payload length is bounded only by tx_data_avail_i.

## Structure
- usb_consts_pkg holds:
  - PID enums and the token/data/handshake type encodings.
  - New constants UsbCrc16Init = 16'hFFFF and UsbCrc16Poly = 16'hA001.
- State enum is local to the module.
- Sub-module usb_fs_crc16: combinational byte update (crc_i, data_i -> crc_o), reusable by the RX CRC checker.

## Test plan
- ACK: start with pid 4'h2, ready=1 -> one byte 0xD2 with byte_last_o=1. tx_pkt_end_o pulses one cycle after eop_done_i.
- DATA1 with payload 0x00: start pid 4'hB, avail for one byte -> bytes 0x4B, 0x00, 0x40, 0xBF, last flag on 0xBF, one tx_data_get_o.
- DATA0 zero-length: pid 4'h3, avail=0 -> bytes 0xC3, 0x00, 0x00; no tx_data_get_o.
- Backpressure: byte_ready_i toggled 1/0 during a 4-byte payload -> byte_o stable while not ready; exactly 4 gets; CRC matches reference model.
- link_reset_i pulsed in StData after 2 bytes -> byte_valid_o low next cycle, busy_o low, no tx_pkt_end_o. A following ACK packet is sent correctly.
- With USB_FS_TX_LEN_LIMIT_EN and MaxPktSizeByte=4, avail held high -> exactly 4 gets, then the CRC bytes follow.

Source files
------------

// File: rtl/usb_consts_pkg.sv
// Shared USB constants: PID encodings, PID type field values and CRC16 parameters.
// Used by the transmit framer and intended for the receive-side CRC checker as well.
package usb_consts_pkg;

  typedef enum logic [3:0] {
    UsbPidOut   = 4'h1,
    UsbPidIn    = 4'h9,
    UsbPidSof   = 4'h5,
    UsbPidSetup = 4'hD,
    UsbPidData0 = 4'h3,
    UsbPidData1 = 4'hB,
    UsbPidData2 = 4'h7,
    UsbPidMData = 4'hF,
    UsbPidAck   = 4'h2,
    UsbPidNak   = 4'hA,
    UsbPidStall = 4'hE,
    UsbPidNyet  = 4'h6,
    UsbPidPre   = 4'hC
  } usb_pid_e;

  // PID[1:0] identifies the packet class.
  typedef enum logic [1:0] {
    UsbPidTypeSpecial   = 2'b00,
    UsbPidTypeToken     = 2'b01,
    UsbPidTypeHandshake = 2'b10,
    UsbPidTypeData      = 2'b11
  } usb_pid_type_e;

  localparam logic [15:0] UsbCrc16Init = 16'hFFFF;
  localparam logic [15:0] UsbCrc16Poly = 16'hA001;

  function automatic logic pid_is_data(input logic [3:0] pid);
    return pid[1:0] == UsbPidTypeData;
  endfunction

endpackage

// File: rtl/usb_fs_crc16.sv
// Combinational USB CRC16 update over one byte, LSB first, reflected polynomial.
// Shared between the transmit framer and the receive checker.
module usb_fs_crc16
  import usb_consts_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_v;

  always_comb begin
    crc_v = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_v[0] ^ data_i[i]) begin
        crc_v = (crc_v >> 1) ^ UsbCrc16Poly;
      end else begin
        crc_v = crc_v >> 1;
      end
    end
    crc_o = crc_v;
  end

endmodule

// File: rtl/usb_fs_nb_tx_pkt.sv
// Byte-level USB full-speed TX packet framer: PID, optional payload, inverted CRC16.
// Optional USB_FS_TX_LEN_LIMIT_EN caps the payload at MaxPktSizeByte bytes.
//
// state     | meaning
// StIdle    | waiting for a start strobe
// StPid     | PID byte presented
// StData    | payload bytes streamed
// StCrcLo   | low CRC byte presented
// StCrcHi   | high CRC byte presented (last)
// StWaitEop | waiting for the serializer to finish EOP
module usb_fs_nb_tx_pkt
  import usb_consts_pkg::*;
#(
  parameter int MaxPktSizeByte = 64
) (
  input  logic       clk_48mhz_i,
  input  logic       rst_ni,
  input  logic       link_reset_i,
  input  logic       tx_pkt_start_i,
  input  logic [3:0] tx_pid_i,
  input  logic       tx_data_avail_i,
  output logic       tx_data_get_o,
  input  logic [7:0] tx_data_i,
  output logic       tx_pkt_end_o,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       byte_last_o,
  input  logic       eop_done_i,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StPid,
    StData,
    StCrcLo,
    StCrcHi,
    StWaitEop
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic [15:0] crc_q, crc_d, crc_upd;
  logic        pkt_end_q, pkt_end_d;
  logic        data_get;
  logic        len_hit;

  usb_fs_crc16 u_crc16 (
    .crc_i  (crc_q),
    .data_i (tx_data_i),
    .crc_o  (crc_upd)
  );

`ifdef USB_FS_TX_LEN_LIMIT_EN
  localparam int CntW = $clog2(MaxPktSizeByte + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign len_hit = (cnt_q == CntW'(MaxPktSizeByte));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (data_get) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_len_cfg;

  assign len_hit        = 1'b0;
  assign unused_len_cfg = ^MaxPktSizeByte;
`endif

  always_comb begin
    state_d      = state_q;
    pid_d        = pid_q;
    crc_d        = crc_q;
    pkt_end_d    = 1'b0;
    byte_o       = 8'h00;
    byte_valid_o = 1'b0;
    byte_last_o  = 1'b0;
    data_get     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_pkt_start_i) begin
          pid_d   = tx_pid_i;
          crc_d   = UsbCrc16Init;
          state_d = StPid;
        end
      end
      StPid: begin
        byte_o       = {~pid_q, pid_q};
        byte_valid_o = 1'b1;
        byte_last_o  = !pid_is_data(pid_q);
        if (byte_ready_i) begin
          state_d = pid_is_data(pid_q) ? StData : StWaitEop;
        end
      end
      StData: begin
        // An empty engine (or a full packet) ends the payload without sending a byte.
        if (len_hit || !tx_data_avail_i) begin
          state_d = StCrcLo;
        end else begin
          byte_o       = tx_data_i;
          byte_valid_o = 1'b1;
          data_get     = byte_ready_i;
          if (byte_ready_i) begin
            crc_d = crc_upd;
          end
        end
      end
      StCrcLo: begin
        byte_o       = ~crc_q[7:0];
        byte_valid_o = 1'b1;
        if (byte_ready_i) begin
          state_d = StCrcHi;
        end
      end
      StCrcHi: begin
        byte_o       = ~crc_q[15:8];
        byte_valid_o = 1'b1;
        byte_last_o  = 1'b1;
        if (byte_ready_i) begin
          state_d = StWaitEop;
        end
      end
      StWaitEop: begin
        if (eop_done_i) begin
          pkt_end_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A link reset abandons the packet: no end pulse and the pending byte is not taken.
    if (link_reset_i) begin
      state_d   = StIdle;
      pkt_end_d = 1'b0;
      data_get  = 1'b0;
      crc_d     = crc_q;
    end
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pid_q     <= 4'h0;
      crc_q     <= UsbCrc16Init;
      pkt_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pid_q     <= pid_d;
      crc_q     <= crc_d;
      pkt_end_q <= pkt_end_d;
    end
  end

  assign tx_data_get_o = data_get;
  assign tx_pkt_end_o  = pkt_end_q;
  assign busy_o        = (state_q != StIdle);

endmodule
